// File: rtl/enc_pkg.sv
// Shared definitions for the priority arbiter/encoder.
//   state_e    : arbiter FSM states (idle / grant held)
//   MODE_FIXED : fixed priority, highest set index wins
//   MODE_RR    : round-robin, descending search from a rotating pointer
package enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

endpackage

// File: rtl/prio_scan.sv
// Combinational circular priority search.
// Searches req in descending order starting at start, wrapping from 0 to N-1:
// start, start-1, ..., 0, N-1, ..., start+1. The first set bit wins.
// Ports:
//   req   : request vector
//   start : first index examined (must be < N)
//   found : at least one request is set
//   idx   : index of the winning request (0 when none)
module prio_scan #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int          pos;
  logic [IW-1:0] pos_i;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    pos_i = '0;
    for (int j = 0; j < int'(N); j++) begin
      pos = int'(start) - j;
      if (pos < 0) begin
        pos = pos + int'(N);
      end
      pos_i = IW'(pos);
      if (!found && req[pos_i]) begin
        found = 1'b1;
        idx   = pos_i;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_enc.sv
// Registered N-way priority encoder with grant/ack handshake.
// A winner is registered one cycle after requests appear and held until the
// consumer acks it or the granted requester withdraws. RR selects fixed
// priority (highest index wins) or round-robin (rotating descending search).
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req        : request vector, bit i = requester i
//   ack        : consumer releases the current grant (ignored while idle)
//   valid      : a grant is held
//   gnt_idx    : binary index of the granted requester
//   gnt_onehot : one-hot grant, zero while not valid
module prio_arbiter_enc
  import enc_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned RR = 0,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic          valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_onehot
);

  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  oh_q, oh_d;

  logic          take_ack;
  logic [IW-1:0] ack_ptr;
  logic [IW-1:0] scan_start;
  logic          scan_found;
  logic [IW-1:0] scan_idx;

  assign take_ack = (state_q == ST_GRANT) && ack;

  // Pointer after acking winner k is k-1, wrapping explicitly so that it
  // stays below N even when N is not a power of two.
  assign ack_ptr = (idx_q == '0) ? LastIdx : (idx_q - 1'b1);

  // On ack the next winner is searched from the already-updated pointer,
  // which keeps back-to-back grants bubble-free.
  always_comb begin
    scan_start = LastIdx;
    if (RR == MODE_RR) begin
      scan_start = take_ack ? ack_ptr : ptr_q;
    end
  end

  prio_scan #(
    .N  (N),
    .IW (IW)
  ) u_scan (
    .req   (req),
    .start (scan_start),
    .found (scan_found),
    .idx   (scan_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (scan_found) begin
          state_d = ST_GRANT;
          valid_d = 1'b1;
          idx_d   = scan_idx;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          // Ack takes precedence over a simultaneous withdrawal.
          if (RR == MODE_RR) begin
            ptr_d = ack_ptr;
          end
          if (scan_found) begin
            idx_d = scan_idx;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end else if (!req[idx_q]) begin
          // Withdrawal leaves the pointer untouched.
          state_d = ST_IDLE;
          valid_d = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase

    oh_d = valid_d ? (N'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= LastIdx;
      idx_q   <= '0;
      valid_q <= 1'b0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      oh_q    <= oh_d;
    end
  end

  assign valid      = valid_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = oh_q;

endmodule

// File: tb/tb_prio_arbiter_enc.sv
// Self-checking bench for prio_arbiter_enc: fixed N=4, round-robin N=4 and
// round-robin N=6 instances share clock and reset.
module tb_prio_arbiter_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [3:0] req4;
  logic [5:0] req6;

  logic       v_fx, v_rr, v_6;
  logic [1:0] i_fx, i_rr;
  logic [2:0] i_6;
  logic [3:0] o_fx, o_rr;
  logic [5:0] o_6;

  always #5 clk = ~clk;

  prio_arbiter_enc #(.N(4), .RR(0)) dut_fx (
    .clk(clk), .rst(rst), .req(req4), .ack(ack),
    .valid(v_fx), .gnt_idx(i_fx), .gnt_onehot(o_fx)
  );

  prio_arbiter_enc #(.N(4), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req4), .ack(ack),
    .valid(v_rr), .gnt_idx(i_rr), .gnt_onehot(o_rr)
  );

  prio_arbiter_enc #(.N(6), .RR(1)) dut_6 (
    .clk(clk), .rst(rst), .req(req6), .ack(ack),
    .valid(v_6), .gnt_idx(i_6), .gnt_onehot(o_6)
  );

  typedef struct {
    int   sel;
    logic ev;
    int   ei;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   step_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected registered result, and
  // compare it against the selected instance just after the next edge.
  task automatic step(input int sel, input logic r, input logic a, input logic [5:0] rq,
                      input logic ev, input int ei);
    exp_t        e;
    logic [31:0] ov, oi, oo, eo;
    rst  = r;
    ack  = a;
    req4 = rq[3:0];
    req6 = rq;
    sb.push_back('{sel: sel, ev: ev, ei: ei});
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    case (e.sel)
      0:       begin ov = 32'(v_fx); oi = 32'(i_fx); oo = 32'(o_fx); end
      1:       begin ov = 32'(v_rr); oi = 32'(i_rr); oo = 32'(o_rr); end
      default: begin ov = 32'(v_6);  oi = 32'(i_6);  oo = 32'(o_6);  end
    endcase
    eo = e.ev ? (32'd1 << e.ei) : 32'd0;
    check($sformatf("s%0d.valid", step_no), ov, 32'(e.ev));
    check($sformatf("s%0d.idx", step_no), oi, 32'(e.ei));
    check($sformatf("s%0d.onehot", step_no), oo, eo);
  endtask

  initial begin
    rst  = 1'b1;
    ack  = 1'b0;
    req4 = 4'b1111;
    req6 = 6'b001111;

    // Fixed priority, N=4
    step(0, 1, 0, 6'b001111, 0, 0);
    step(0, 1, 0, 6'b001111, 0, 0);
    step(0, 0, 0, 6'b001111, 1, 3);
    step(0, 0, 1, 6'b000000, 0, 0);
    step(0, 0, 0, 6'b001100, 1, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 6'b001100, 1, 3);
    step(0, 0, 1, 6'b000010, 1, 1);
    step(0, 0, 0, 6'b000111, 1, 1);  // higher requests appear, grant held
    step(0, 0, 1, 6'b000111, 1, 2);
    step(0, 0, 1, 6'b000000, 0, 0);
    step(0, 0, 1, 6'b000001, 1, 0);  // ack while idle is ignored

    // Round-robin, N=4
    step(1, 1, 0, 6'b000000, 0, 0);
    check("rr.ptr_reset", 32'(dut_rr.ptr_q), 32'd3);
    step(1, 0, 0, 6'b001111, 1, 3);
    step(1, 0, 1, 6'b001111, 1, 2);
    step(1, 0, 1, 6'b001111, 1, 1);
    step(1, 0, 1, 6'b001111, 1, 0);
    step(1, 0, 1, 6'b001111, 1, 3);
    step(1, 0, 1, 6'b000000, 0, 0);

    // Withdrawal
    step(1, 1, 0, 6'b000000, 0, 0);
    step(1, 0, 0, 6'b000100, 1, 2);
    step(1, 0, 1, 6'b000100, 1, 2);
    check("rr.ptr_after_ack2", 32'(dut_rr.ptr_q), 32'd1);
    step(1, 0, 0, 6'b000001, 0, 0);
    check("rr.ptr_withdraw", 32'(dut_rr.ptr_q), 32'd1);
    step(1, 0, 0, 6'b000001, 1, 0);
    check("rr.ptr_regrant", 32'(dut_rr.ptr_q), 32'd1);
    step(1, 0, 1, 6'b000100, 1, 2);
    check("rr.ptr_after_ack0", 32'(dut_rr.ptr_q), 32'd3);
    step(1, 0, 1, 6'b000100, 1, 2);
    check("rr.ptr_before_rst", 32'(dut_rr.ptr_q), 32'd1);

    // Reset mid-grant with ack pending
    step(1, 1, 1, 6'b001111, 0, 0);
    check("rr.ptr_mid_rst", 32'(dut_rr.ptr_q), 32'd3);
    step(1, 0, 0, 6'b001111, 1, 3);
    step(1, 0, 1, 6'b000111, 1, 2);  // ack beats withdrawal
    check("rr.ptr_ack_withdraw", 32'(dut_rr.ptr_q), 32'd2);

    // Round-robin, N=6
    step(2, 1, 0, 6'b000000, 0, 0);
    step(2, 0, 0, 6'b100001, 1, 5);
    step(2, 0, 1, 6'b100001, 1, 0);
    step(2, 0, 1, 6'b100001, 1, 5);
    step(2, 0, 1, 6'b100001, 1, 0);
    check("n6.ptr_after_ack5", 32'(dut_6.ptr_q), 32'd4);
    step(2, 0, 1, 6'b100001, 1, 5);
    check("n6.ptr_wrap", 32'(dut_6.ptr_q), 32'd5);
    step(2, 0, 1, 6'b000000, 0, 0);
    check("n6.ptr_after_idle", 32'(dut_6.ptr_q), 32'd4);
    step(2, 0, 0, 6'b010000, 1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
